uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter: serialises one parallel word per valid/ready

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 29 ++
 rtl/uart_tx_frame.sv | 126 ++++++++++++
 tb/tb_uart_tx_frame.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: parity modes, transmitter FSM states
// and a frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int frame_bits(int data_w, int parity, int stop_bits);
    return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: one-cycle tick every CLKS_PER_BIT clocks, restartable so a
// new frame always gets full-length bits.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises it
// as start, data LSB first, optional parity and 1-2 stop bits on a registered line.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == int'(PAR_ODD));

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W=%0d outside 5..9", DATA_W);
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT=%0d below 2", CLKS_PER_BIT);
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY=%0d not 0, 1 or 2", PARITY);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS=%0d not 1 or 2", STOP_BITS);
  end

  // Handshake: a word moves when tx_valid && tx_ready at a rising edge;
  // tx_ready is high only in IDLE, and tx_data is ignored at all other times.
  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic [IDX_W-1:0]  bit_idx;
  logic              tick, accept, done_nxt, last_data, last_stop;

  assign tx_ready  = (state == IDLE);
  assign busy      = !tx_ready;
  assign accept    = tx_valid && tx_ready;
  assign last_data = (bit_idx == LAST_DATA);
  assign last_stop = (bit_idx == LAST_STOP);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE:  if (accept) state_nxt = START;
      START: if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && last_data) begin
          state_nxt = (PARITY != int'(PAR_NONE)) ? uart_pkg::PARITY : STOP;
        end
      end
      uart_pkg::PARITY: if (tick) state_nxt = STOP;
      STOP: begin
        if (tick && last_stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Parity is fixed at capture time so the shift register can be consumed freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
    end else if (accept) begin
      shreg   <= tx_data;
      par_bit <= (^tx_data) ^ ODD;
      bit_idx <= '0;
    end else if (tick && state == DATA) begin
      shreg   <= shreg >> 1;
      bit_idx <= last_data ? '0 : bit_idx + 1'b1;
    end else if (tick && state == STOP) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // The line follows the state one clock later, so every bit lasts CLKS_PER_BIT clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= 1'b1;
    end else begin
      unique case (state)
        START:            tx <= 1'b0;
        DATA:             tx <= shreg[0];
        uart_pkg::PARITY: tx <= par_bit;
        default:          tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter sets driven with directed and random
// words, each frame compared cycle by cycle against a frame model.
module tb_uart_tx_frame;

  localparam int CPB = 4;
  localparam int N   = 4;

  int cfg_dw   [N] = '{8, 8, 8, 7};
  int cfg_par  [N] = '{0, 1, 2, 0};
  int cfg_stop [N] = '{1, 1, 1, 2};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [8:0]   tx_data [N];
  logic [N-1:0] tx_valid, tx_ready, tx, busy, tx_done;

  int total    = 0;
  int pass_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));
  uart_tx_frame #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(tx_done[3]));

  // scoreboard
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  // reference model: frame as a bit list, index 0 is the first bit on the line
  function automatic int nbits(input int i);
    return 1 + cfg_dw[i] + ((cfg_par[i] != 0) ? 1 : 0) + cfg_stop[i];
  endfunction

  function automatic logic [15:0] frame_of(input int i, input logic [8:0] w);
    logic [15:0] f;
    int ones;
    int p;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    p    = 1;
    for (int b = 0; b < cfg_dw[i]; b++) begin
      f[p] = w[b];
      ones += int'(w[b]);
      p++;
    end
    if (cfg_par[i] == 1) f[p] = ((ones % 2) == 1);
    else if (cfg_par[i] == 2) f[p] = ((ones % 2) == 0);
    return f;
  endfunction

  function automatic logic [8:0] mask_word(input int i, input logic [8:0] w);
    logic [8:0] m;
    m = 9'((1 << cfg_dw[i]) - 1);
    return w & m;
  endfunction

  // driver tasks; every task starts and ends 1 ns after a rising edge
  task automatic accept(input int i, input logic [8:0] w, input bit keep, output bit ok);
    ok          = 1'b0;
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (tx_ready[i]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!keep) tx_valid[i] = 1'b0;
    if (!ok) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic run_frame(input int i, input logic [8:0] w_in, input string tag,
                           input int poke, output logic [127:0] o_tx);
    bit          ok;
    int          t;
    int          len;
    logic [8:0]  w;
    logic [15:0] f;
    logic [127:0] e_tx, e_done, e_ready, e_busy, o_done, o_ready, o_busy;
    logic        pk_ready;
    w   = mask_word(i, w_in);
    f   = frame_of(i, w);
    t   = nbits(i) * CPB;
    len = t + 2;
    {e_tx, e_done, e_ready, e_busy} = '0;
    {o_tx, o_done, o_ready, o_busy} = '0;
    pk_ready = 1'b0;
    for (int s = 0; s < len; s++) begin
      e_tx[s]    = (s == 0 || s > t) ? 1'b1 : f[(s - 1) / CPB];
      e_ready[s] = (s >= t);
      e_busy[s]  = (s < t);
      e_done[s]  = (s == t);
    end
    accept(i, w, 1'b0, ok);
    for (int s = 0; s < len; s++) begin
      if (s > 0) begin
        @(posedge clk);
        #1;
      end
      o_tx[s]    = tx[i];
      o_done[s]  = tx_done[i];
      o_ready[s] = tx_ready[i];
      o_busy[s]  = busy[i];
      if (poke > 0 && s == poke) begin
        pk_ready    = tx_ready[i];
        tx_data[i]  = 9'($urandom);
        tx_valid[i] = 1'b1;
      end
      if (poke > 0 && s == poke + 1) tx_valid[i] = 1'b0;
    end
    check({tag, "_tx"}, o_tx, e_tx);
    check({tag, "_done"}, o_done, e_done);
    check({tag, "_ready"}, o_ready, e_ready);
    check({tag, "_busy"}, o_busy, e_busy);
    if (poke > 0) check({tag, "_poke_ready"}, 128'(pk_ready), 128'd0);
  endtask

  task automatic back_to_back(input int i, input logic [8:0] w1_in, input logic [8:0] w2_in);
    bit          ok;
    bit          dropped;
    int          t;
    int          len;
    logic [8:0]  w1, w2;
    logic [15:0] f1, f2;
    logic [127:0] e_tx, e_done, o_tx, o_done;
    w1  = mask_word(i, w1_in);
    w2  = mask_word(i, w2_in);
    f1  = frame_of(i, w1);
    f2  = frame_of(i, w2);
    t   = nbits(i) * CPB;
    len = 2 * t + 3;
    {e_tx, e_done, o_tx, o_done} = '0;
    for (int s = 0; s < len; s++) begin
      if (s == 0 || s == t + 1 || s > 2 * t + 1) e_tx[s] = 1'b1;
      else if (s <= t) e_tx[s] = f1[(s - 1) / CPB];
      else e_tx[s] = f2[(s - t - 2) / CPB];
      e_done[s] = (s == t) || (s == 2 * t + 1);
    end
    accept(i, w1, 1'b1, ok);
    tx_data[i] = w2;
    dropped    = 1'b0;
    for (int s = 0; s < len; s++) begin
      if (s > 0) begin
        @(posedge clk);
        #1;
      end
      o_tx[s]   = tx[i];
      o_done[s] = tx_done[i];
      if (!dropped && $countones(o_done) == 1 && !tx_ready[i]) begin
        tx_valid[i] = 1'b0;
        dropped     = 1'b1;
      end
    end
    tx_valid[i] = 1'b0;
    check("b2b_tx", o_tx, e_tx);
    check("b2b_done", o_done, e_done);
    check("b2b_done_count", 128'($countones(o_done)), 128'd2);
  endtask

  initial begin
    bit           ok;
    logic [127:0] wv;
    logic [9:0]   mid;
    int           inst;
    int           gap;
    tx_valid = '0;
    for (int i = 0; i < N; i++) tx_data[i] = '0;

    // asynchronous reset before any clock activity matters
    #2 rst = 1'b0;
    #1;
    check("rst_async_tx", 128'(tx), 128'hF);
    check("rst_async_ready", 128'(tx_ready), 128'hF);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 128'(tx), 128'hF);
    check("rst_ready", 128'(tx_ready), 128'hF);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_done", 128'(tx_done), 128'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // 0xA5, no parity, one stop bit: line values at the middle of each bit
    run_frame(0, 9'h0A5, "t1_a5", 0, wv);
    for (int j = 0; j < 10; j++) mid[j] = wv[1 + j * CPB + CPB / 2];
    check("t1_bit_values", 128'(mid), 128'(10'b1101001010));

    // parity bit is frame bit 9 for 8 data bits
    run_frame(1, 9'h007, "t2_even_07", 0, wv);
    check("t2_even_07_par", 128'(wv[1 + 9 * CPB + CPB / 2]), 128'd1);
    run_frame(2, 9'h007, "t2_odd_07", 0, wv);
    check("t2_odd_07_par", 128'(wv[1 + 9 * CPB + CPB / 2]), 128'd0);
    run_frame(1, 9'h0A5, "t2_even_a5", 0, wv);
    check("t2_even_a5_par", 128'(wv[1 + 9 * CPB + CPB / 2]), 128'd0);

    // 7 data bits, two stop bits
    run_frame(3, 9'h07F, "t3_7f", 0, wv);
    check("t3_start", 128'(wv[CPB:1]), 128'h0);
    check("t3_data_ones", 128'(wv[8 * CPB:CPB + 1]), 128'hFFF_FFFF);
    check("t3_stop_high", 128'(wv[10 * CPB:8 * CPB + 1]), 128'hFF);

    back_to_back(0, 9'h011, 9'h022);

    // reset in the middle of data bit 3 (frame bit 4) of 0xA5
    accept(0, 9'h0A5, 1'b0, ok);
    repeat (4 * CPB + 2) @(posedge clk);
    #1;
    check("t5_in_bit3_tx", 128'(tx[0]), 128'd0);
    check("t5_in_bit3_ready", 128'(tx_ready[0]), 128'd0);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_tx", 128'(tx[0]), 128'd1);
    check("t5_rst_ready", 128'(tx_ready[0]), 128'd1);
    check("t5_rst_busy", 128'(busy[0]), 128'd0);
    check("t5_rst_done", 128'(tx_done[0]), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 9'h03C, "t5_after_3c", 0, wv);

    // new data and valid while busy must leave the frame untouched
    run_frame(0, 9'h05A, "t6_poke", 6, wv);
    run_frame(3, 9'h055, "t6_poke_dw7", 9, wv);

    // random words on random configurations, some with mid-frame pokes
    for (int r = 0; r < 16; r++) begin
      inst = $urandom_range(0, N - 1);
      gap  = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      run_frame(inst, 9'($urandom_range(0, 511)), $sformatf("rand%0d_i%0d", r, inst),
                (r % 3 == 0) ? $urandom_range(2, 10) : 0, wv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
